seq_lut_loader: RTL and testbench

- Upstream feeder for the sequencer FSM.
- Accepts LUT entries over a valid/ready stream and holds the sequencer in reset while it drives the LUT write port (one entry per `lut_wen` pulse, auto-increment addressing).
- Releases the sequencer on command, monitors completion, and re-asserts sequencer reset on done or abort.
- Also reports entry count, an order-sensitive checksum and error status.

---
 rtl/seq_lut_loader_if.sv | 12 +
 rtl/seq_lut_loader.sv | 155 +++++++++++++++
 tb/tb_seq_lut_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_lut_loader_if.sv
// LUT entry stream between the configuration source and the loader.
interface seq_lut_loader_if #(
    parameter int unsigned DATA_W = 29
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_last;

    modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/seq_lut_loader.sv
// LUT loader for the sequencer: streams entries into the LUT while the
// sequencer is held in reset, then releases it on command and re-arms on
// done/abort. Reports entry count, rotate-XOR checksum and overflow.
module seq_lut_loader #(
    parameter int unsigned DATA_W    = 29,
    parameter int unsigned LUT_DEPTH = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                load_req_i,
    input  logic                start_i,
    input  logic                abort_i,
    seq_lut_loader_if.slave     cfg,
    output logic                seq_reset_o,
    output logic                lut_wen_o,
    output logic [DATA_W-1:0]   lut_write_data_o,
    input  logic                seq_done_i,
    output logic [CNT_W-1:0]    entry_count_o,
    output logic [DATA_W-1:0]   checksum_o,
    output logic [2:0]          loader_state_o,
    output logic                done_o,
    output logic                err_overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(LUT_DEPTH);

    state_t              state_q;
    state_t              state_d;
    logic                done_prev_q;
    logic                not_full;
    logic                done_rise;
    logic                accept;
    logic                overflow;
    logic                enter_load;

    logic                seq_reset_d;
    logic                done_d;
    logic                wen_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [CNT_W-1:0]    count_d;
    logic [DATA_W-1:0]   cks_d;
    logic                err_d;

    assign not_full       = (entry_count_o < DEPTH);
    assign done_rise      = seq_done_i & ~done_prev_q;
    assign loader_state_o = state_q;

    // State register and seq_done edge-detect history
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_prev_q <= seq_done_i;
        end
    end

    // Next state; abort beats load_req beats start, and a beat coinciding with a command is dropped
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        overflow   = 1'b0;
        enter_load = 1'b0;
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else if (load_req_i && (state_q != S_RUN)) begin
            state_d    = S_LOAD;
            enter_load = 1'b1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (cfg.cfg_valid && not_full) begin
                        accept = 1'b1;
                        if (cfg.cfg_last) begin
                            state_d = S_ARMED;
                        end
                    end else if (cfg.cfg_valid) begin
                        overflow = 1'b1;
                        state_d  = S_ERR;
                    end
                end
                S_ARMED, S_DONE: begin
                    if (start_i) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (done_rise) begin
                        state_d = S_DONE;
                    end
                end
                S_IDLE, S_ERR: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output next-values; seq_reset/done follow the state being entered so they move with it
    always_comb begin
        cfg.cfg_ready = (state_q == S_LOAD) && not_full;
        seq_reset_d   = (state_d != S_RUN);
        done_d        = (state_d == S_DONE);
        wen_d         = accept;
        wdata_d       = lut_write_data_o;
        count_d       = entry_count_o;
        cks_d         = checksum_o;
        err_d         = err_overflow_o;
        if (enter_load) begin
            count_d = '0;
            cks_d   = '0;
            err_d   = 1'b0;
        end
        if (accept) begin
            wdata_d = cfg.cfg_data;
            count_d = entry_count_o + CNT_W'(1);
            cks_d   = {checksum_o[DATA_W-2:0], checksum_o[DATA_W-1]} ^ cfg.cfg_data;
        end
        if (overflow) begin
            err_d = 1'b1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            seq_reset_o      <= 1'b1;
            done_o           <= 1'b0;
            lut_wen_o        <= 1'b0;
            lut_write_data_o <= '0;
            entry_count_o    <= '0;
            checksum_o       <= '0;
            err_overflow_o   <= 1'b0;
        end else begin
            seq_reset_o      <= seq_reset_d;
            done_o           <= done_d;
            lut_wen_o        <= wen_d;
            lut_write_data_o <= wdata_d;
            entry_count_o    <= count_d;
            checksum_o       <= cks_d;
            err_overflow_o   <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_lut_loader.sv
// Bench for seq_lut_loader: a deep (32) and a shallow (4) instance share stimulus;
// both are compared every cycle against an entry-list reference model.
module tb_seq_lut_loader;

    localparam int DEPTH_A = 32;
    localparam int DEPTH_B = 4;
    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_ARMED = 2, ST_RUN = 3, ST_DONE = 4, ST_ERR = 5;

    logic        clk;
    logic        rst_n, load_req, start, abort, valid, last, seq_done;
    logic [28:0] data;

    logic [2:0]  o_state [2];
    logic        o_seqrst [2];
    logic        o_wen [2];
    logic        o_done [2];
    logic        o_err [2];
    logic        o_ready [2];
    logic [28:0] o_wd [2];
    logic [28:0] o_cks [2];
    logic [5:0]  o_cnt [2];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: list of written entries per instance
    int          m_st [2];
    int          m_cnt [2];
    logic [28:0] m_ent [2][64];
    bit          m_err [2];
    bit          m_wen [2];
    bit          m_prev [2];
    logic [28:0] m_wd [2];

    seq_lut_loader_if #(.DATA_W(29)) cfg_a ();
    seq_lut_loader_if #(.DATA_W(29)) cfg_b ();

    assign cfg_a.cfg_valid = valid;
    assign cfg_a.cfg_data  = data;
    assign cfg_a.cfg_last  = last;
    assign cfg_b.cfg_valid = valid;
    assign cfg_b.cfg_data  = data;
    assign cfg_b.cfg_last  = last;
    assign o_ready[0]      = cfg_a.cfg_ready;
    assign o_ready[1]      = cfg_b.cfg_ready;

    seq_lut_loader #(.DATA_W(29), .LUT_DEPTH(DEPTH_A), .CNT_W(6)) dut_a (
        .clk(clk), .reset_n_i(rst_n), .load_req_i(load_req), .start_i(start), .abort_i(abort),
        .cfg(cfg_a), .seq_reset_o(o_seqrst[0]), .lut_wen_o(o_wen[0]), .lut_write_data_o(o_wd[0]),
        .seq_done_i(seq_done), .entry_count_o(o_cnt[0]), .checksum_o(o_cks[0]),
        .loader_state_o(o_state[0]), .done_o(o_done[0]), .err_overflow_o(o_err[0])
    );

    seq_lut_loader #(.DATA_W(29), .LUT_DEPTH(DEPTH_B), .CNT_W(6)) dut_b (
        .clk(clk), .reset_n_i(rst_n), .load_req_i(load_req), .start_i(start), .abort_i(abort),
        .cfg(cfg_b), .seq_reset_o(o_seqrst[1]), .lut_wen_o(o_wen[1]), .lut_write_data_o(o_wd[1]),
        .seq_done_i(seq_done), .entry_count_o(o_cnt[1]), .checksum_o(o_cks[1]),
        .loader_state_o(o_state[1]), .done_o(o_done[1]), .err_overflow_o(o_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, ab, v, last, sd;
        logic [28:0] d;
        logic [2:0]  e_state;
        logic        e_wen, e_seqrst, e_done;
        logic [5:0]  e_cnt;
        logic [28:0] e_wd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(int ld, int st, int ab, int v, int lst, int sd, logic [28:0] d,
                                int es, int ew, int esr, int ed, int ec, logic [28:0] ewd);
        vec_t r;
        r.ld = 1'(ld); r.st = 1'(st); r.ab = 1'(ab); r.v = 1'(v); r.last = 1'(lst); r.sd = 1'(sd);
        r.d = d;
        r.e_state = 3'(es); r.e_wen = 1'(ew); r.e_seqrst = 1'(esr); r.e_done = 1'(ed);
        r.e_cnt = 6'(ec); r.e_wd = ewd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // rotate-left-by-one then XOR, folded over the written entries in order
    function automatic logic [28:0] m_cks(int d);
        logic [28:0] c;
        c = '0;
        for (int i = 0; i < m_cnt[d]; i++) c = {c[27:0], c[28]} ^ m_ent[d][i];
        return c;
    endfunction

    function automatic void model_step(int d);
        int dep;
        bit rdy;
        bit rise;
        dep = (d == 0) ? DEPTH_A : DEPTH_B;
        rdy = (m_st[d] == ST_LOAD) && (m_cnt[d] < dep);
        m_wen[d] = 1'b0;
        if (!rst_n) begin
            m_st[d] = ST_IDLE; m_cnt[d] = 0; m_err[d] = 1'b0; m_wd[d] = '0; m_prev[d] = 1'b0;
            return;
        end
        rise = seq_done && !m_prev[d];
        m_prev[d] = seq_done;
        if (abort && m_st[d] != ST_IDLE) begin
            m_st[d] = ST_IDLE;
        end else if (load_req && m_st[d] != ST_RUN) begin
            m_st[d] = ST_LOAD; m_cnt[d] = 0; m_err[d] = 1'b0;
        end else if (m_st[d] == ST_LOAD && valid) begin
            if (rdy) begin
                m_ent[d][m_cnt[d]] = data;
                m_cnt[d]++;
                m_wen[d] = 1'b1;
                m_wd[d] = data;
                if (last) m_st[d] = ST_ARMED;
            end else begin
                m_err[d] = 1'b1;
                m_st[d] = ST_ERR;
            end
        end else if ((m_st[d] == ST_ARMED || m_st[d] == ST_DONE) && start) begin
            m_st[d] = ST_RUN;
        end else if (m_st[d] == ST_RUN && rise) begin
            m_st[d] = ST_DONE;
        end
    endfunction

    task automatic check_dut(input int d);
        string p;
        int dep;
        p = (d == 0) ? "A" : "B";
        dep = (d == 0) ? DEPTH_A : DEPTH_B;
        chk({p, ".state"},  64'(o_state[d]),  64'(m_st[d]));
        chk({p, ".seqrst"}, 64'(o_seqrst[d]), 64'(m_st[d] != ST_RUN));
        chk({p, ".wen"},    64'(o_wen[d]),    64'(m_wen[d]));
        chk({p, ".wdata"},  64'(o_wd[d]),     64'(m_wd[d]));
        chk({p, ".count"},  64'(o_cnt[d]),    64'(m_cnt[d]));
        chk({p, ".cksum"},  64'(o_cks[d]),    64'(m_cks(d)));
        chk({p, ".done"},   64'(o_done[d]),   64'(m_st[d] == ST_DONE));
        chk({p, ".err"},    64'(o_err[d]),    64'(m_err[d]));
        chk({p, ".ready"},  64'(o_ready[d]),  64'((m_st[d] == ST_LOAD) && (m_cnt[d] < dep)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    task automatic drive(input int ld, input int st, input int ab, input int v, input int lst,
                         input int sd, input logic [28:0] d);
        load_req = 1'(ld); start = 1'(st); abort = 1'(ab);
        valid = 1'(v); last = 1'(lst); seq_done = 1'(sd); data = d;
        tick();
    endtask

    initial begin
        logic [28:0] d1, d2, d3, d4, d5;
        d1 = 29'd134742416; d2 = 29'd202375208; d3 = 29'd269222912;
        d4 = 29'd402917328; d5 = 29'd470025394;

        tbl[0]  = mk(1,0,0,0,0,0,'0, 1,0,1,0,0,'0);
        tbl[1]  = mk(0,0,0,1,0,0,d1, 1,1,1,0,1,d1);
        tbl[2]  = mk(0,0,0,1,0,0,d2, 1,1,1,0,2,d2);
        tbl[3]  = mk(0,0,0,1,0,0,d3, 1,1,1,0,3,d3);
        tbl[4]  = mk(0,0,0,1,0,0,d4, 1,1,1,0,4,d4);
        tbl[5]  = mk(0,0,0,1,1,0,d5, 2,1,1,0,5,d5);
        tbl[6]  = mk(0,0,0,0,0,0,'0, 2,0,1,0,5,d5);
        tbl[7]  = mk(0,1,0,0,0,0,'0, 3,0,0,0,5,d5);
        tbl[8]  = mk(0,0,0,0,0,0,'0, 3,0,0,0,5,d5);
        tbl[9]  = mk(0,0,0,0,0,1,'0, 4,0,1,1,5,d5);
        tbl[10] = mk(0,0,0,0,0,1,'0, 4,0,1,1,5,d5);
        tbl[11] = mk(0,1,0,0,0,1,'0, 3,0,0,0,5,d5);
        tbl[12] = mk(0,0,0,0,0,0,'0, 3,0,0,0,5,d5);
        tbl[13] = mk(0,0,0,0,0,1,'0, 4,0,1,1,5,d5);
        tbl[14] = mk(1,0,0,0,0,0,'0, 1,0,1,0,0,d5);
        tbl[15] = mk(0,0,1,0,0,0,'0, 0,0,1,0,0,d5);
        tbl[16] = mk(0,1,0,0,0,0,'0, 0,0,1,0,0,d5);

        for (int d = 0; d < 2; d++) begin
            m_st[d] = ST_IDLE; m_cnt[d] = 0; m_err[d] = 1'b0;
            m_wen[d] = 1'b0; m_prev[d] = 1'b0; m_wd[d] = '0;
        end

        // reset for two cycles
        rst_n = 1'b0;
        drive(0,0,0,0,0,0,'0);
        drive(0,0,0,0,0,0,'0);
        rst_n = 1'b1;

        // basic load, run, done and re-run
        for (int i = 0; i < 17; i++) begin
            load_req = tbl[i].ld; start = tbl[i].st; abort = tbl[i].ab;
            valid = tbl[i].v; last = tbl[i].last; seq_done = tbl[i].sd; data = tbl[i].d;
            tick();
            chk($sformatf("tbl%0d.state", i),  64'(o_state[0]),  64'(tbl[i].e_state));
            chk($sformatf("tbl%0d.wen", i),    64'(o_wen[0]),    64'(tbl[i].e_wen));
            chk($sformatf("tbl%0d.seqrst", i), 64'(o_seqrst[0]), 64'(tbl[i].e_seqrst));
            chk($sformatf("tbl%0d.done", i),   64'(o_done[0]),   64'(tbl[i].e_done));
            chk($sformatf("tbl%0d.count", i),  64'(o_cnt[0]),    64'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d.wdata", i),  64'(o_wd[0]),     64'(tbl[i].e_wd));
        end

        // checksum is order sensitive
        drive(1,0,0,0,0,0,'0);
        drive(0,0,0,1,0,0,29'h1);
        drive(0,0,0,1,1,0,29'h1);
        chk("cksum_1_1", 64'(o_cks[0]), 64'h3);
        drive(1,0,0,0,0,0,'0);
        drive(0,0,0,1,0,0,29'h1);
        drive(0,0,0,1,1,0,29'h2);
        chk("cksum_1_2", 64'(o_cks[0]), 64'h0);

        // overflow on the depth-4 instance
        drive(1,0,0,0,0,0,'0);
        for (int i = 0; i < 4; i++) drive(0,0,0,1,0,0,29'($urandom()));
        chk("ovf.ready_full", 64'(o_ready[1]), 64'h0);
        chk("ovf.count4",     64'(o_cnt[1]),   64'd4);
        drive(0,0,0,1,0,0,29'($urandom()));
        chk("ovf.state_err",  64'(o_state[1]), 64'(ST_ERR));
        chk("ovf.err",        64'(o_err[1]),   64'h1);
        chk("ovf.no_wen",     64'(o_wen[1]),   64'h0);
        chk("ovf.a_count5",   64'(o_cnt[0]),   64'd5);
        drive(0,0,0,0,0,0,'0);
        drive(1,0,0,0,0,0,'0);
        chk("ovf.err_clr",    64'(o_err[1]),   64'h0);
        chk("ovf.reload",     64'(o_state[1]), 64'(ST_LOAD));

        // abort and command priority
        drive(0,0,0,1,1,0,29'h155);
        drive(0,1,0,0,0,0,'0);
        chk("abort.running",  64'(o_state[0]),  64'(ST_RUN));
        drive(0,0,1,0,0,0,'0);
        chk("abort.idle",     64'(o_state[0]),  64'(ST_IDLE));
        chk("abort.seqrst",   64'(o_seqrst[0]), 64'h1);
        drive(1,0,0,0,0,0,'0);
        drive(1,0,1,0,0,0,'0);
        chk("abort_ld.idle",  64'(o_state[0]),  64'(ST_IDLE));
        drive(0,1,0,0,0,0,'0);
        chk("idle_start",     64'(o_state[0]),  64'(ST_IDLE));

        // reset in the middle of a load
        drive(1,0,0,0,0,0,'0);
        drive(0,0,0,1,0,0,29'h1abc);
        drive(0,0,0,1,0,0,29'h0def);
        rst_n = 1'b0;
        drive(0,0,0,0,0,0,'0);
        rst_n = 1'b1;
        chk("rst.state",  64'(o_state[0]),  64'(ST_IDLE));
        chk("rst.count",  64'(o_cnt[0]),    64'h0);
        chk("rst.cksum",  64'(o_cks[0]),    64'h0);
        chk("rst.wdata",  64'(o_wd[0]),     64'h0);
        chk("rst.seqrst", 64'(o_seqrst[0]), 64'h1);

        // stalls in the stream
        drive(1,0,0,0,0,0,'0);
        drive(0,0,0,1,0,0,29'h11);
        drive(0,0,0,0,0,0,29'h22);
        drive(0,0,0,1,0,0,29'h33);
        drive(0,0,0,0,0,0,29'h44);
        drive(0,0,0,1,1,0,29'h55);
        chk("stall.count", 64'(o_cnt[0]),   64'd3);
        chk("stall.state", 64'(o_state[0]), 64'(ST_ARMED));

        // randomized traffic against the model
        seq_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            load_req = ($urandom_range(0, 29) == 0);
            start    = ($urandom_range(0, 14) == 0);
            abort    = ($urandom_range(0, 49) == 0);
            valid    = ($urandom_range(0, 9) < 6);
            last     = ($urandom_range(0, 19) == 0);
            data     = 29'($urandom());
            if ($urandom_range(0, 9) == 0) seq_done = ~seq_done;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
